// File: rtl/rx_len_pkg.sv
// Shared constants and FSM encoding for the 10G RX frame length controller.
package rx_len_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DROP = 2'd2
  } state_e;

  localparam int MIN_LEN_DEF   = 64;
  localparam int MAX_LEN_DEF   = 1518;
  localparam int JUMBO_LEN_DEF = 9018;
  localparam int CNT_W_DEF     = 12;
  localparam int MAX_WORDS     = (2 ** CNT_W_DEF) - 1;

endpackage

// File: rtl/rx_len_ctrl_counter.sv
// Receive data word counter: synchronous load-to-zero has priority over count enable.
module counter #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)    cnt_d = '0;
    else if (en) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign count = cnt_q;

endmodule

// File: rtl/rx_len_ctrl.sv
// RX frame length controller: gates the word counter between SFD and /T/, builds the
// byte length and runt/oversize/error flags, and emits a one-cycle length report.
module rx_len_ctrl
  import rx_len_pkg::*;
#(
  parameter int MIN_LEN   = MIN_LEN_DEF,
  parameter int MAX_LEN   = MAX_LEN_DEF,
  parameter int JUMBO_LEN = JUMBO_LEN_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic             rxclk,
  input  logic             reset,
  input  logic             sfd_det,
  input  logic             term_det,
  input  logic [2:0]       term_pos,
  input  logic             rx_err,
  input  logic             cfg_jumbo,
  output logic             receiving,
  output logic [CNT_W-1:0] frame_cnt,
  output logic             len_valid,
  output logic [CNT_W+2:0] frame_len,
  output logic             len_short,
  output logic             len_long,
  output logic             len_err
);

  localparam int LW = CNT_W + 3;
  // Saturated report length: all-ones word count, zero tail (15'h7FF8 at 12 bits).
  localparam logic [LW-1:0]    SAT_LEN = {{CNT_W{1'b1}}, 3'b000};
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e          state_q, state_d;
  logic            restart_q, restart_d;
  logic            err_seen_q, err_seen_d;
  logic            len_valid_q, len_valid_d;
  logic [LW-1:0]   frame_len_q, frame_len_d;
  logic            len_short_q, len_short_d;
  logic            len_long_q, len_long_d;
  logic            len_err_q, len_err_d;

  logic            rpt_fire, frame_start;
  logic [CNT_W-1:0] cnt_eff;
  logic [LW-1:0]   calc_len, lim;

  counter #(.WIDTH(CNT_W)) data_counter (
    .clk   (rxclk),
    .reset (reset),
    .load  (~receiving),
    .en    (receiving),
    .count (frame_cnt)
  );

  // During the forced restart cycle the counter still shows the old frame's count.
  assign cnt_eff  = restart_q ? '0 : frame_cnt;
  assign calc_len = {cnt_eff, 3'b000} + {{(LW-3){1'b0}}, (term_det ? term_pos : 3'd0)};
  assign lim      = cfg_jumbo ? LW'(JUMBO_LEN) : LW'(MAX_LEN);

  always_ff @(posedge rxclk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (sfd_det) state_d = RECV;
      RECV: begin
        if (term_det)                state_d = IDLE;
        else if (sfd_det)            state_d = RECV;
        else if (cnt_eff == CNT_MAX) state_d = DROP;
      end
      DROP: begin
        if (term_det)     state_d = IDLE;
        else if (sfd_det) state_d = RECV;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    receiving   = (state_q == RECV) & ~term_det & ~restart_q;
    rpt_fire    = (state_q != IDLE) & (term_det | sfd_det);
    frame_start = sfd_det & ((state_q == IDLE) | ~term_det);
    restart_d   = (state_q == RECV) & sfd_det & ~term_det;

    err_seen_d = err_seen_q;
    if (frame_start)                       err_seen_d = 1'b0;
    else if ((state_q != IDLE) && rx_err)  err_seen_d = 1'b1;

    len_valid_d = rpt_fire;
    frame_len_d = frame_len_q;
    len_short_d = len_short_q;
    len_long_d  = len_long_q;
    len_err_d   = len_err_q;
    if (rpt_fire) begin
      // A report without /T/ means the next SFD cut the frame short.
      len_err_d = err_seen_q | rx_err | ~term_det;
      if (state_q == DROP) begin
        frame_len_d = SAT_LEN;
        len_short_d = 1'b0;
        len_long_d  = 1'b1;
      end else begin
        frame_len_d = calc_len;
        len_short_d = calc_len < LW'(MIN_LEN);
        len_long_d  = calc_len > lim;
      end
    end
  end

  always_ff @(posedge rxclk or posedge reset) begin
    if (reset) begin
      restart_q   <= 1'b0;
      err_seen_q  <= 1'b0;
      len_valid_q <= 1'b0;
      frame_len_q <= '0;
      len_short_q <= 1'b0;
      len_long_q  <= 1'b0;
      len_err_q   <= 1'b0;
    end else begin
      restart_q   <= restart_d;
      err_seen_q  <= err_seen_d;
      len_valid_q <= len_valid_d;
      frame_len_q <= frame_len_d;
      len_short_q <= len_short_d;
      len_long_q  <= len_long_d;
      len_err_q   <= len_err_d;
    end
  end

  assign len_valid = len_valid_q;
  assign frame_len = frame_len_q;
  assign len_short = len_short_q;
  assign len_long  = len_long_q;
  assign len_err   = len_err_q;

endmodule
